// File: rtl/vector_checker_pkg.sv
// Shared types and helpers for the vector response checker.
package vector_checker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } checker_state_t;

    // Pointer width for a FIFO of the given depth (at least one bit).
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/vector_response_checker_fifo.sv
// Expected-value FIFO for the response checker: DEPTH entries of DW bits,
// separate occupancy counter, synchronous flush that overrides push/pop.
module checker_fifo
    import vector_checker_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  logic [DW-1:0]                wdata,
    output logic [DW-1:0]                rdata,
    output logic                         full,
    output logic                         empty,
    output logic [ptr_width(DEPTH):0]    count
);

    localparam int unsigned PW = ptr_width(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // Next pointers and occupancy; flush returns everything to empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (do_push && !do_pop)      count_d = count_q + (PW+1)'(1);
            else if (do_pop && !do_push) count_d = count_q - (PW+1)'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since occupancy gates reads.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/vector_response_checker.sv
// Response checker: consumes expected values from the stimulus side and
// compares them against DUT samples on obs_valid, keeping a verdict,
// case/mismatch counters and a capture of the first failure.
// Optional macro VECTOR_RESPONSE_CHECKER_MASK_EN adds a per-entry
// don't-care mask (exp_mask) stored alongside each expected value.
module vector_response_checker
    import vector_checker_pkg::*;
#(
    parameter int unsigned W            = 8,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned CW           = 16,
    parameter int unsigned STOP_ON_FAIL = 0
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start,
    input  logic          finish,
    input  logic          exp_valid,
    output logic          exp_ready,
    input  logic [W-1:0]  exp_data,
`ifdef VECTOR_RESPONSE_CHECKER_MASK_EN
    input  logic [W-1:0]  exp_mask,
`endif
    input  logic          obs_valid,
    input  logic [W-1:0]  obs_data,
    output logic          busy,
    output logic          pass,
    output logic          fail,
    output logic          underflow,
    output logic [CW-1:0] case_count,
    output logic [CW-1:0] mismatch_count,
    output logic [CW-1:0] first_fail_idx,
    output logic [W-1:0]  first_fail_exp,
    output logic [W-1:0]  first_fail_obs
);

`ifdef VECTOR_RESPONSE_CHECKER_MASK_EN
    localparam int unsigned DW = 2 * W;
`else
    localparam int unsigned DW = W;
`endif
    localparam int unsigned PW = ptr_width(DEPTH);

    checker_state_t state_q, state_d;
    logic           underflow_q, underflow_d;
    logic [CW-1:0]  case_count_q, case_count_d;
    logic [CW-1:0]  mismatch_count_q, mismatch_count_d;
    logic [CW-1:0]  first_fail_idx_q, first_fail_idx_d;
    logic [W-1:0]   first_fail_exp_q, first_fail_exp_d;
    logic [W-1:0]   first_fail_obs_q, first_fail_obs_d;

    logic [DW-1:0]  fifo_wdata, fifo_rdata;
    logic           fifo_full, fifo_empty;
    logic [PW:0]    fifo_count;
    logic [W-1:0]   head_data, head_mask, cmp_exp;
    logic           do_push, do_pop, obs_fire, mism, empty_after;

`ifdef VECTOR_RESPONSE_CHECKER_MASK_EN
    assign fifo_wdata = {exp_mask, exp_data};
    assign head_mask  = fifo_rdata[DW-1:W];
`else
    assign fifo_wdata = exp_data;
    assign head_mask  = '0;
`endif
    assign head_data  = fifo_rdata[W-1:0];

    assign exp_ready = (state_q == RUN) && !fifo_full;
    assign do_push   = !start && exp_valid && exp_ready;
    assign obs_fire  = !start && (state_q == RUN) && obs_valid;
    assign do_pop    = obs_fire && !fifo_empty;
    assign cmp_exp   = fifo_empty ? '0 : head_data;
    assign mism      = obs_fire &&
                       (fifo_empty || (((head_data ^ obs_data) & ~head_mask) != '0));
    // FIFO is empty after this edge: nothing queued and no push, or the
    // last entry is popped while no push arrives.
    assign empty_after = !do_push &&
                         ((fifo_count == '0) ||
                          ((fifo_count == (PW+1)'(1)) && do_pop));

    checker_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (start),
        .push    (do_push),
        .pop     (do_pop),
        .wdata   (fifo_wdata),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Next-state, counter and first-failure capture logic; start has priority.
    always_comb begin
        state_d          = state_q;
        underflow_d      = underflow_q;
        case_count_d     = case_count_q;
        mismatch_count_d = mismatch_count_q;
        first_fail_idx_d = first_fail_idx_q;
        first_fail_exp_d = first_fail_exp_q;
        first_fail_obs_d = first_fail_obs_q;
        if (start) begin
            state_d          = RUN;
            underflow_d      = 1'b0;
            case_count_d     = '0;
            mismatch_count_d = '0;
            first_fail_idx_d = '0;
            first_fail_exp_d = '0;
            first_fail_obs_d = '0;
        end else if (state_q == RUN) begin
            if (obs_fire) begin
                case_count_d = case_count_q + CW'(1);
                if (fifo_empty) underflow_d = 1'b1;
                if (mism) begin
                    if (mismatch_count_q != '1)
                        mismatch_count_d = mismatch_count_q + CW'(1);
                    if (mismatch_count_q == '0) begin
                        first_fail_idx_d = case_count_q;
                        first_fail_exp_d = cmp_exp;
                        first_fail_obs_d = obs_data;
                    end
                end
            end
            if (mism && (STOP_ON_FAIL != 0)) begin
                state_d = FAIL;
            end else if (finish) begin
                if ((mismatch_count_d == '0) && !underflow_d && empty_after)
                    state_d = PASS;
                else
                    state_d = FAIL;
            end
        end
    end

    // Status registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            underflow_q      <= 1'b0;
            case_count_q     <= '0;
            mismatch_count_q <= '0;
            first_fail_idx_q <= '0;
            first_fail_exp_q <= '0;
            first_fail_obs_q <= '0;
        end else begin
            state_q          <= state_d;
            underflow_q      <= underflow_d;
            case_count_q     <= case_count_d;
            mismatch_count_q <= mismatch_count_d;
            first_fail_idx_q <= first_fail_idx_d;
            first_fail_exp_q <= first_fail_exp_d;
            first_fail_obs_q <= first_fail_obs_d;
        end
    end

    assign busy           = (state_q == RUN);
    assign pass           = (state_q == PASS);
    assign fail           = (state_q == FAIL);
    assign underflow      = underflow_q;
    assign case_count     = case_count_q;
    assign mismatch_count = mismatch_count_q;
    assign first_fail_idx = first_fail_idx_q;
    assign first_fail_exp = first_fail_exp_q;
    assign first_fail_obs = first_fail_obs_q;

endmodule

// File: tb/tb_vector_response_checker.sv
// Directed bench for vector_response_checker (W=8, DEPTH=4, CW=16).
module tb_vector_response_checker;

    logic        clock;
    logic        reset_n;
    logic        start, finish;
    logic        exp_valid, exp_ready;
    logic [7:0]  exp_data;
`ifdef VECTOR_RESPONSE_CHECKER_MASK_EN
    logic [7:0]  exp_mask;
`endif
    logic        obs_valid;
    logic [7:0]  obs_data;
    logic        busy, pass, fail, underflow;
    logic [15:0] case_count, mismatch_count, first_fail_idx;
    logic [7:0]  first_fail_exp, first_fail_obs;

    int tests  = 0;
    int failed = 0;

    vector_response_checker #(
        .W            (8),
        .DEPTH        (4),
        .CW           (16),
        .STOP_ON_FAIL (0)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .finish         (finish),
        .exp_valid      (exp_valid),
        .exp_ready      (exp_ready),
        .exp_data       (exp_data),
`ifdef VECTOR_RESPONSE_CHECKER_MASK_EN
        .exp_mask       (exp_mask),
`endif
        .obs_valid      (obs_valid),
        .obs_data       (obs_data),
        .busy           (busy),
        .pass           (pass),
        .fail           (fail),
        .underflow      (underflow),
        .case_count     (case_count),
        .mismatch_count (mismatch_count),
        .first_fail_idx (first_fail_idx),
        .first_fail_exp (first_fail_exp),
        .first_fail_obs (first_fail_obs)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; finish = 0; exp_valid = 0; exp_data = '0;
        obs_valid = 0; obs_data = '0;
`ifdef VECTOR_RESPONSE_CHECKER_MASK_EN
        exp_mask = '0;
`endif
    endtask

    initial begin
        idle_inputs();
        reset_n = 0;
        step(); step();
        check("rst_busy", busy, 0);
        check("rst_pass", pass, 0);
        check("rst_fail", fail, 0);
        check("rst_ready", exp_ready, 0);
        check("rst_case", case_count, 0);
        check("rst_mism", mismatch_count, 0);
        reset_n = 1;
        step();

        // Matching stream
        start = 1; step(); start = 0;
        check("t1_busy", busy, 1);
        check("t1_ready", exp_ready, 1);
        exp_valid = 1;
        exp_data = 8'h11; step();
        exp_data = 8'h22; step();
        exp_data = 8'h33; step();
        exp_valid = 0;
        obs_valid = 1;
        obs_data = 8'h11; step();
        obs_data = 8'h22; step();
        obs_data = 8'h33; step();
        obs_valid = 0;
        finish = 1; step(); finish = 0;
        check("t1_pass", pass, 1);
        check("t1_fail", fail, 0);
        check("t1_case", case_count, 3);
        check("t1_mism", mismatch_count, 0);
        check("t1_busy_end", busy, 0);

        // Single mismatch as case index 2 of 4, with overlapping push/pop
        start = 1; step(); start = 0;
        check("t2_cleared", case_count, 0);
        exp_valid = 1; exp_data = 8'h01; step();
        exp_data = 8'h02; obs_valid = 1; obs_data = 8'h01; step();
        exp_data = 8'hA5; obs_data = 8'h02; step();
        exp_data = 8'h04; obs_data = 8'hA4; step();
        check("t2_mism_now", mismatch_count, 1);
        check("t2_case_now", case_count, 3);
        exp_valid = 0; obs_data = 8'h04; step();
        obs_valid = 0;
        finish = 1; step(); finish = 0;
        check("t2_fail", fail, 1);
        check("t2_pass", pass, 0);
        check("t2_case", case_count, 4);
        check("t2_mism", mismatch_count, 1);
        check("t2_idx", first_fail_idx, 2);
        check("t2_exp", first_fail_exp, 8'hA5);
        check("t2_obs", first_fail_obs, 8'hA4);

        // Underflow
        start = 1; step(); start = 0;
        obs_valid = 1; obs_data = 8'h07; step(); obs_valid = 0;
        check("t3_uflow", underflow, 1);
        check("t3_mism", mismatch_count, 1);
        check("t3_case", case_count, 1);
        check("t3_idx", first_fail_idx, 0);
        check("t3_exp", first_fail_exp, 0);
        check("t3_obs", first_fail_obs, 8'h07);
        finish = 1; step(); finish = 0;
        check("t3_fail", fail, 1);

        // Backpressure, full push+pop, leftover
        start = 1; step(); start = 0;
        check("t4_uflow_clr", underflow, 0);
        exp_valid = 1;
        exp_data = 8'h10; step();
        exp_data = 8'h11; step();
        exp_data = 8'h12; step();
        check("t4_ready_3", exp_ready, 1);
        exp_data = 8'h13; step();
        check("t4_ready_full", exp_ready, 0);
        exp_data = 8'h14; step();
        check("t4_ready_still", exp_ready, 0);
        exp_data = 8'h55; obs_valid = 1; obs_data = 8'h10; step();
        check("t4_ready_after_pop", exp_ready, 1);
        check("t4_case1", case_count, 1);
        exp_valid = 0;
        obs_data = 8'h11; step();
        obs_data = 8'h12; step();
        obs_valid = 0;
        check("t4_mism", mismatch_count, 0);
        finish = 1; step(); finish = 0;
        check("t4_fail", fail, 1);
        check("t4_case", case_count, 3);
        check("t4_mism_end", mismatch_count, 0);
        check("t4_uflow", underflow, 0);

        // start and finish together
        start = 1; finish = 1; step(); start = 0; finish = 0;
        check("t5_busy", busy, 1);
        check("t5_fail", fail, 0);
        check("t5_case", case_count, 0);
        check("t5_ready", exp_ready, 1);

        // Reset in the middle of RUN
        exp_valid = 1; exp_data = 8'h77; step(); exp_valid = 0;
        obs_valid = 1; obs_data = 8'h78; step(); obs_valid = 0;
        check("t6_mism_pre", mismatch_count, 1);
        #2 reset_n = 0;
        #1;
        check("t6_busy", busy, 0);
        check("t6_case", case_count, 0);
        check("t6_mism", mismatch_count, 0);
        check("t6_ffobs", first_fail_obs, 0);
        check("t6_ready", exp_ready, 0);
        step();
        reset_n = 1;
        step();

        // finish outside RUN is ignored
        finish = 1; step(); finish = 0;
        check("t7_busy", busy, 0);
        check("t7_pass", pass, 0);
        check("t7_fail", fail, 0);

`ifdef VECTOR_RESPONSE_CHECKER_MASK_EN
        start = 1; step(); start = 0;
        exp_valid = 1; exp_data = 8'hF0; exp_mask = 8'h0F; step();
        exp_valid = 0;
        obs_valid = 1; obs_data = 8'hF9; step(); obs_valid = 0;
        check("t8_masked", mismatch_count, 0);
        exp_valid = 1; exp_data = 8'hF0; exp_mask = 8'h00; step();
        exp_valid = 0;
        obs_valid = 1; obs_data = 8'hF9; step(); obs_valid = 0;
        check("t8_unmasked", mismatch_count, 1);
        check("t8_idx", first_fail_idx, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/vector_response_checker.md
Name: vector_response_checker

Overview:
- Reader end of the vector stimulus/expect protocol. The stimulus side pushes expected output values; this block consumes them and compares each against the DUT output sampled on obs_valid.
- Keeps pass/fail status, counts cases and mismatches, and captures the first failure.
- Sits beside a generated DUT in self-checking simulation and on-FPGA regression harnesses.

Parameters:
- W, 8, width of compared data.
- DEPTH, 4, expected-value FIFO depth; power of two, at least 2.
- CW, 16, width of the case, mismatch and index counters.
- STOP_ON_FAIL, 0, when 1 the first mismatch moves the block straight to FAIL.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse: flush the FIFO, clear all counters and captures, enter RUN.
- finish  in  1  pulse: end of test, resolve the verdict.
- exp_valid  in  1  expected value offered.
- exp_ready  out  1  expected value accepted when exp_valid and exp_ready are both high.
- exp_data  in  W  expected value.
- obs_valid  in  1  DUT output sample present; cannot be stalled.
- obs_data  in  W  observed DUT output.
- busy  out  1  high while in RUN.
- pass  out  1  sticky verdict.
- fail  out  1  sticky verdict.
- underflow  out  1  sticky: an observation arrived while the FIFO was empty.
- case_count  out  CW  comparisons performed.
- mismatch_count  out  CW  failed comparisons, saturating.
- first_fail_idx  out  CW  case index of the first failure.
- first_fail_exp  out  W  expected value of the first failure.
- first_fail_obs  out  W  observed value of the first failure.

Behaviour:
- Reset (asynchronous assert, synchronous deassert): state IDLE, FIFO empty, every output 0.
- States: IDLE, RUN, PASS, FAIL.
- IDLE/PASS/FAIL to RUN on start. start also flushes the FIFO and clears counters, captures, underflow and verdicts; start wins over every other input in the same cycle.
- RUN to PASS on finish when mismatch_count = 0, no underflow and the FIFO is empty. Otherwise RUN to FAIL on finish; leftover expected values count as a failure.
- RUN to FAIL immediately on the first mismatch when STOP_ON_FAIL = 1.
- finish outside RUN is ignored.
- exp_ready = (state == RUN) and FIFO not full. It is based on the registered full flag: no pass-through while full, even when a pop happens in the same cycle.
- In RUN, obs_valid with the FIFO non-empty:
  - pop the FIFO head, increment case_count;
  - compare head against obs_data;
  - on inequality, increment mismatch_count (saturates at 2^CW-1);
  - if this is the first failure since start, capture first_fail_idx = pre-increment case_count, first_fail_exp = head, first_fail_obs = obs_data.
- In RUN, obs_valid with the FIFO empty: set underflow, count a mismatch, capture first_fail_exp = 0 and first_fail_obs = obs_data if first; case_count still increments.
- Push and pop in the same cycle are legal at any occupancy where the push is accepted; occupancy is unchanged.
- FIFO pointers wrap modulo DEPTH, with a separate count register 0..DEPTH.
- case_count wraps modulo 2^CW.
- All status outputs are registered and visible the cycle after the triggering edge.
- obs_valid outside RUN is ignored.
- Reset in the middle of RUN discards all state.

Optional Feature:
- Macro: VECTOR_RESPONSE_CHECKER_MASK_EN.
- Defined: adds input exp_mask [W], stored in the FIFO alongside exp_data. Bits set in the mask are don't-care; a mismatch is ((head ^ obs) & ~mask) != 0.
- Undefined: no port, no extra storage, full-width equality.

Decomposition:
- Package vector_checker_pkg:
  - checker_state_t enum (IDLE=0, RUN=1, PASS=2, FAIL=3);
  - localparam function clog2-based pointer width helper.
- Sub-module checker_fifo (DEPTH x W, plus the mask when enabled):
  - push/pop/full/empty/count;
  - synchronous flush input driven by start.

Test Plan:
- Matching stream: reset, start, push 0x11, 0x22, 0x33, three obs cycles with the same values, finish -> pass=1, fail=0, case_count=3, mismatch_count=0.
- Single mismatch: expect 0xA5, observe 0xA4 as case 2 of 4, STOP_ON_FAIL=0, finish -> fail=1, mismatch_count=1, first_fail_idx=2, first_fail_exp=0xA5, first_fail_obs=0xA4.
- Underflow: start, obs_valid with obs_data=0x07 and nothing pushed -> underflow=1, mismatch_count=1 next cycle; finish -> fail=1.
- Backpressure and leftover: DEPTH=4, push 5 values with no obs -> exp_ready low after 4 accepted; finish -> fail=1 (FIFO not empty).
- Simultaneous and reset cases:
  - FIFO full, push plus obs in the same cycle -> push refused, count drops to 3;
  - start and finish together -> RUN with counters cleared;
  - reset_n low mid-RUN -> all outputs 0 without waiting for a clock edge.
- Mask enabled: expect 0xF0 with mask 0x0F, observe 0xF9 -> no mismatch; mask 0x00 -> mismatch.
